interleaver_top: RTL and testbench
==================================

INTERLEAVER_TOP -- requirements
Module: interleaver_top

Interface
REQ-001 SHALL have parameter Ncbps, default 192, meaning coded bits per block (OFDM symbol).
REQ-002 SHALL have parameter Ncpc, default 2, meaning coded bits per subcarrier (2 = QPSK).
REQ-003 SHALL have parameter s, default Ncpc/2, meaning the second-permutation group size.
REQ-004 SHALL have parameter d, default 16, meaning the first-permutation column count.
REQ-005 SHALL have port: clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port: resetN  input  1  reset, asynchronous and active-high (asserted when 1).
REQ-007 SHALL have port: data_in  input  1  serial coded bit from the FEC.
REQ-008 SHALL have port: valid_in  input  1  data_in valid; a bit is accepted when valid_in && ready_out.
REQ-009 SHALL have port: ready_out  output  1  the interleaver can accept a bit this cycle.
REQ-010 SHALL have port: data_out  output  1  interleaved output bit.
REQ-011 SHALL have port: data_out_index  output  8  output position j of data_out within its block (8 = $clog2(Ncbps) at default).
REQ-012 SHALL have port: valid_interleaver  output  1  data_out and data_out_index are valid.
REQ-013 SHALL have port: ready_in  input  1  downstream ready; an output bit is consumed when valid_interleaver && ready_in.

Function
REQ-014 SHALL store accepted bits in natural order k = 0..Ncbps-1 into a write bank of a two-bank (ping-pong) Ncbps-bit buffer.
REQ-015 SHALL compute m_k = (Ncbps/d)*(k mod d) + floor(k/d) and j_k = s*floor(m_k/s) + ((m_k + Ncbps - floor(d*m_k/Ncbps)) mod s).
REQ-016 SHALL emit the read bank in natural order k, presenting data_out = bit k and data_out_index = j_k, so the data_out_index values of a block form a permutation of 0..Ncbps-1.
REQ-017 SHALL swap banks when the write bank holds Ncbps bits and the read bank is empty, or when its last bit is consumed in the same cycle.
REQ-018 SHALL register data_out, data_out_index, and valid_interleaver, giving a latency of one clock from the acceptance of bit Ncbps-1 to the first valid output of that block.
REQ-019 SHALL sustain one bit per clock in and out with no bubbles when valid_in and ready_in are held high.
REQ-020 SHALL hold data_out, data_out_index, and valid_interleaver stable while valid_interleaver=1 and ready_in=0.
REQ-021 SHALL deassert ready_out only while the write bank is full and the read bank has not been drained.
REQ-022 SHALL wrap the write and read counters from Ncbps-1 to 0, and SHALL NOT emit a partial block.

Reset
REQ-023 SHALL, while resetN=1, force ready_out=0, valid_interleaver=0, data_out=0, data_out_index=0, both counters to 0, and both banks to empty.
REQ-024 SHALL assert ready_out on the first rising clk edge after resetN falls.
REQ-025 SHALL, on reset asserted mid-block, discard all partial and pending data; the first block after reset starts at k=0.

Configuration
REQ-026 SHALL, with INTERLEAVER_SVA_EN defined, compile assertions checking: no acceptance while ready_out=0; output stability under backpressure; unique data_out_index within each block. Without the macro, no assertion code is compiled and function is identical.

Structure
REQ-027 SHALL take Ncbps/Ncpc/s/d defaults, the index-width constant, and an index-permutation function computing j_k from k from a shared package interleaver_pkg.
REQ-028 SHALL place the k-to-j_k computation in one sub-module, interleaver_index_gen, which is combinational from k.

Verification
REQ-029 SHALL cover: resetN=1 -> ready_out=0, valid_interleaver=0, data_out_index=0; resetN=0 -> ready_out=1 next edge.
REQ-030 SHALL cover, at defaults: output at k=0,1,16,191 -> data_out_index=0,12,1,191 respectively.
REQ-031 SHALL cover: 5 back-to-back blocks of 0x2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA (MSB = k=0), with ready_in=1, assembled by data_out_index -> blocks 1..4 equal 0x4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E.
REQ-032 SHALL cover: ready_in=0 for 20 cycles mid-block -> outputs frozen, ready_out falls once the write bank fills, and no bit is lost or duplicated.
REQ-033 SHALL cover: reset at k=100 of a block -> no valid output until Ncbps new bits have been accepted, and the resulting block is correct.

Source files
------------

// File: rtl/interleaver_pkg.sv
// rtl/interleaver_pkg.sv - shared constants and index permutation for the block interleaver
//
// Purpose: default block geometry, index width and the k -> j_k permutation
// used by interleaver_index_gen (and available to any model of the block).
package interleaver_pkg;

    localparam int NCBPS_DEF = 192;            // coded bits per block
    localparam int NCPC_DEF  = 2;              // coded bits per subcarrier
    localparam int S_DEF     = NCPC_DEF / 2;   // second-permutation group size
    localparam int D_DEF     = 16;             // first-permutation column count
    localparam int IDX_W     = $clog2(NCBPS_DEF);

    // Two-stage permutation: the first spreads adjacent bits across columns,
    // the second rotates bits within groups of s so neighbours alternate
    // between more and less reliable constellation bits.
    function automatic logic [IDX_W-1:0] perm_index(
        input int unsigned k,
        input int unsigned ncbps,
        input int unsigned d,
        input int unsigned s
    );
        int unsigned m;
        int unsigned jv;
        m  = (ncbps / d) * (k % d) + (k / d);
        jv = s * (m / s) + ((m + ncbps - ((d * m) / ncbps)) % s);
        return jv[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/interleaver_index_gen.sv
// rtl/interleaver_index_gen.sv - combinational natural-order to interleaved-position mapping
//
// Purpose: maps read position k of a block to its output position j_k.
// Ports:
//   i_k  in   IDX_W  natural-order bit position within the block
//   o_j  out  IDX_W  interleaved position j_k
module interleaver_index_gen
    import interleaver_pkg::*;
#(
    parameter int Ncbps = NCBPS_DEF,
    parameter int d     = D_DEF,
    parameter int s     = S_DEF
) (
    input  logic [IDX_W-1:0] i_k,
    output logic [IDX_W-1:0] o_j
);

    always_comb begin
        o_j = perm_index(32'(i_k), Ncbps, d, s);
    end

endmodule

// File: rtl/interleaver_top.sv
// rtl/interleaver_top.sv - ping-pong block bit interleaver with ready/valid handshakes
//
// Purpose: collects Ncbps serial bits into the write bank while the other bank
// is emitted in natural order k, each bit tagged with its interleaved
// position j_k. Banks swap as soon as the write bank is full and the read
// bank has been drained, so streaming runs at one bit per clock.
// Ports:
//   clk                in   1      rising-edge clock
//   resetN             in   1      asynchronous reset, active high
//   data_in            in   1      serial coded bit
//   valid_in           in   1      data_in valid
//   ready_out          out  1      a bit can be accepted this cycle
//   data_out           out  1      output bit (natural order k)
//   data_out_index     out  IDX_W  interleaved position j_k of data_out
//   valid_interleaver  out  1      data_out/data_out_index valid
//   ready_in           in   1      downstream consumes when high with valid
// Build option: INTERLEAVER_SVA_EN compiles handshake/stability/uniqueness assertions.
module interleaver_top
    import interleaver_pkg::*;
#(
    parameter int Ncbps = NCBPS_DEF,
    parameter int Ncpc  = NCPC_DEF,
    parameter int s     = Ncpc / 2,
    parameter int d     = D_DEF
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic [IDX_W-1:0] data_out_index,
    output logic             valid_interleaver,
    input  logic             ready_in
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(Ncbps - 1);

    // Bank storage is not reset: the empty/full flags alone decide what is live.
    logic [Ncbps-1:0] r_bank0;
    logic [Ncbps-1:0] r_bank1;
    logic             r_wsel;      // bank being written; the other is read
    logic [IDX_W-1:0] r_wcnt;
    logic [IDX_W-1:0] r_rcnt;
    logic             r_wfull;     // write bank complete, waiting for a swap
    logic             r_rvalid;    // read bank still holds undrained bits
    logic             r_ready;
    logic             r_dout;
    logic [IDX_W-1:0] r_idx;
    logic             r_vout;

    logic             w_acc;
    logic             w_acc_last;
    logic             w_out_free;
    logic             w_rd;
    logic             w_rd_last;
    logic             w_wbank_full;
    logic             w_swap;
    logic             w_wfull_nxt;
    logic             w_rd_bit;
    logic [IDX_W-1:0] w_j;

    interleaver_index_gen #(
        .Ncbps (Ncbps),
        .d     (d),
        .s     (s)
    ) u_index_gen (
        .i_k (r_rcnt),
        .o_j (w_j)
    );

    always_comb begin
        w_acc        = valid_in && r_ready;
        w_acc_last   = w_acc && (r_wcnt == LAST);
        // The output register can take a new bit when empty or being consumed.
        w_out_free   = !r_vout || ready_in;
        w_rd         = r_rvalid && w_out_free;
        w_rd_last    = w_rd && (r_rcnt == LAST);
        // Swap on the very edge that completes the write bank, so the first
        // bit of the block reaches the output register one clock later.
        w_wbank_full = r_wfull || w_acc_last;
        w_swap       = w_wbank_full && (!r_rvalid || w_rd_last);
        w_wfull_nxt  = w_wbank_full && !w_swap;
        w_rd_bit     = r_wsel ? r_bank0[r_rcnt] : r_bank1[r_rcnt];
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            if (r_wsel) begin
                r_bank1[r_wcnt] <= data_in;
            end else begin
                r_bank0[r_wcnt] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_wsel   <= 1'b0;
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_wfull  <= 1'b0;
            r_rvalid <= 1'b0;
            r_ready  <= 1'b0;
            r_dout   <= 1'b0;
            r_idx    <= '0;
            r_vout   <= 1'b0;
        end else begin
            r_wfull  <= w_wfull_nxt;
            r_ready  <= !w_wfull_nxt;
            r_rvalid <= w_swap || (r_rvalid && !w_rd_last);
            if (w_swap) begin
                r_wsel <= !r_wsel;
            end
            if (w_acc) begin
                r_wcnt <= w_acc_last ? '0 : r_wcnt + 1'b1;
            end
            if (w_rd) begin
                r_rcnt <= w_rd_last ? '0 : r_rcnt + 1'b1;
                r_vout <= 1'b1;
                r_dout <= w_rd_bit;
                r_idx  <= w_j;
            end else if (ready_in) begin
                r_vout <= 1'b0;
            end
        end
    end

    assign ready_out         = r_ready;
    assign data_out          = r_dout;
    assign data_out_index    = r_idx;
    assign valid_interleaver = r_vout;

`ifdef INTERLEAVER_SVA_EN
    logic [Ncbps-1:0] r_seen;
    logic [IDX_W-1:0] r_ocnt;

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_seen <= '0;
            r_ocnt <= '0;
        end else if (r_vout && ready_in) begin
            if (r_ocnt == LAST) begin
                r_seen <= '0;
                r_ocnt <= '0;
            end else begin
                r_seen[r_idx] <= 1'b1;
                r_ocnt        <= r_ocnt + 1'b1;
            end
        end
    end

    a_no_accept_when_busy : assert property (@(posedge clk) disable iff (resetN)
        !r_ready |=> $stable(r_wcnt));

    a_stable_backpressure : assert property (@(posedge clk) disable iff (resetN)
        (r_vout && !ready_in) |=> (r_vout && $stable(r_dout) && $stable(r_idx)));

    a_unique_index : assert property (@(posedge clk) disable iff (resetN)
        (r_vout && ready_in) |-> !r_seen[r_idx]);
`endif

endmodule

// File: tb/tb_interleaver_top.sv
// tb/tb_interleaver_top.sv - directed self-checking bench for interleaver_top
module tb_interleaver_top;

    localparam int N = 192;

    logic       clk;
    logic       resetN;
    logic       data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic [7:0] data_out_index;
    logic       valid_interleaver;
    logic       ready_in;

    interleaver_top dut (
        .clk               (clk),
        .resetN            (resetN),
        .data_in           (data_in),
        .valid_in          (valid_in),
        .ready_out         (ready_out),
        .data_out          (data_out),
        .data_out_index    (data_out_index),
        .valid_interleaver (valid_interleaver),
        .ready_in          (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] in_blk;
    logic [N-1:0] exp_blk;
    logic [N-1:0] out_blk;
    logic [N-1:0] seen;

    int n_cmp;
    int n_bad;
    int src_k;
    int n_acc;
    int out_pos;
    int blk_cnt;
    int dup_cnt;
    int stp;
    int last_acc_stp;
    int first_valid_stp;
    bit idx_chk_en;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample just after, and account for
    // the handshakes that the next rising edge will complete.
    task automatic step(input logic vin, input logic rin);
        @(negedge clk);
        valid_in = vin;
        ready_in = rin;
        data_in  = in_blk[N-1-src_k];
        #1;
        stp++;
        if (valid_interleaver && first_valid_stp < 0) first_valid_stp = stp;
        if (valid_in && ready_out) begin
            n_acc++;
            if (n_acc == N) last_acc_stp = stp;
            src_k = (src_k == N-1) ? 0 : src_k + 1;
        end
        if (valid_interleaver && ready_in) begin
            if (seen[data_out_index]) dup_cnt++;
            seen[data_out_index] = 1'b1;
            out_blk[N-1-int'(data_out_index)] = data_out;
            if (idx_chk_en && blk_cnt == 0) begin
                case (out_pos)
                    0:   chk("idx_k0",   N'(data_out_index), N'(0));
                    1:   chk("idx_k1",   N'(data_out_index), N'(12));
                    16:  chk("idx_k16",  N'(data_out_index), N'(1));
                    191: chk("idx_k191", N'(data_out_index), N'(191));
                    default: ;
                endcase
            end
            if (out_pos == N-1) begin
                chk($sformatf("block%0d", blk_cnt), out_blk, exp_blk);
                blk_cnt++;
                out_pos = 0;
                seen    = '0;
            end else begin
                out_pos++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nr_cnt;
        int bubbles;
        int frozen_err;
        int stall_left;
        int early;
        int pre;
        bit stalled;
        bit saw_nr;
        logic snap_v;
        logic snap_d;
        logic [7:0] snap_i;

        in_blk  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
        exp_blk = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
        n_cmp = 0; n_bad = 0; src_k = 0; n_acc = 0; out_pos = 0; blk_cnt = 0;
        dup_cnt = 0; stp = 0; last_acc_stp = -1; first_valid_stp = -1;
        idx_chk_en = 1'b0; out_blk = '0; seen = '0;
        resetN = 1'b1; valid_in = 1'b0; ready_in = 1'b0; data_in = 1'b0;

        // Reset state, with the source already offering data.
        repeat (2) @(negedge clk);
        valid_in = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", N'(ready_out), N'(0));
        chk("rst_valid", N'(valid_interleaver), N'(0));
        chk("rst_index", N'(data_out_index), N'(0));
        chk("rst_data",  N'(data_out), N'(0));
        valid_in = 1'b0;
        resetN   = 1'b0;
        #1;
        chk("rel_ready_pre_edge", N'(ready_out), N'(0));
        @(posedge clk);
        #1;
        chk("rel_ready_post_edge", N'(ready_out), N'(1));

        // Five back-to-back blocks at full rate.
        idx_chk_en = 1'b1;
        nr_cnt = 0; bubbles = 0;
        for (int i = 0; i < 1300 && blk_cnt < 5; i++) begin
            step(n_acc < 5*N, 1'b1);
            if (!ready_out) nr_cnt++;
            if (first_valid_stp >= 0 && blk_cnt < 5 && !valid_interleaver) bubbles++;
        end
        idx_chk_en = 1'b0;
        chk("stream_blocks", N'(blk_cnt), N'(5));
        chk("stream_ready_low", N'(nr_cnt), N'(0));
        chk("stream_bubbles", N'(bubbles), N'(0));
        // Accepting edge is the one right after step last_acc_stp.
        chk("first_latency", N'(first_valid_stp - (last_acc_stp + 1)), N'(1));

        // Backpressure for 20 cycles near the end of a read block.
        n_acc = 0; blk_cnt = 0; out_pos = 0; seen = '0;
        stalled = 1'b0; stall_left = 0; frozen_err = 0; saw_nr = 1'b0;
        snap_v = 1'b0; snap_d = 1'b0; snap_i = '0;
        for (int i = 0; i < 2000 && blk_cnt < 3; i++) begin
            if (!stalled && blk_cnt == 1 && out_pos == 180) begin
                stalled    = 1'b1;
                stall_left = 20;
            end
            step(n_acc < 3*N, !(stall_left > 0));
            if (stall_left > 0) begin
                if (stall_left == 20) begin
                    snap_v = valid_interleaver;
                    snap_d = data_out;
                    snap_i = data_out_index;
                end else if (valid_interleaver !== snap_v || data_out !== snap_d ||
                             data_out_index !== snap_i) begin
                    frozen_err++;
                end
                if (!ready_out) saw_nr = 1'b1;
                stall_left--;
            end
        end
        chk("bp_valid_held", N'(snap_v), N'(1));
        chk("bp_frozen", N'(frozen_err), N'(0));
        chk("bp_ready_fell", N'(saw_nr), N'(1));
        chk("bp_blocks", N'(blk_cnt), N'(3));
        chk("dup_index", N'(dup_cnt), N'(0));

        // Reset partway into a block (k = 100), then one fresh block.
        n_acc = 0;
        for (int i = 0; i < 400 && n_acc < N + 100; i++) begin
            step(1'b1, 1'b1);
        end
        chk("mid_k", N'(src_k), N'(100));
        @(negedge clk);
        resetN = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", N'(valid_interleaver), N'(0));
        chk("mid_rst_ready", N'(ready_out), N'(0));
        resetN = 1'b0;
        src_k = 0; n_acc = 0; blk_cnt = 0; out_pos = 0; seen = '0; early = 0;
        for (int i = 0; i < 600 && blk_cnt < 1; i++) begin
            pre = n_acc;
            step(n_acc < N, 1'b1);
            if (valid_interleaver && pre < N) early++;
        end
        chk("post_rst_early_valid", N'(early), N'(0));
        chk("post_rst_blocks", N'(blk_cnt), N'(1));
        chk("post_rst_dup", N'(dup_cnt), N'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
